// File: rtl/rx_align_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_align_pkg
// Description : Shared constants and state encoding for the receive-lane
//               comma aligner.
// Revision    : 1.0  initial release
// ============================================================================
package rx_align_pkg;

    localparam int SYM_W = 10;

    // K28.5 in both running disparities, first-transmitted bit (a) at the MSB.
    localparam logic [SYM_W-1:0] K28_5_RDN = 10'b0011111010;
    localparam logic [SYM_W-1:0] K28_5_RDP = 10'b1100000101;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } align_state_e;

endpackage
`default_nettype wire

// File: rtl/comma_window_detect.sv
`default_nettype none
// ============================================================================
// Module      : comma_window_detect
// Description : Combinational K28.5 compare on a 10-bit window, either
//               running disparity.
// Revision    : 1.0  initial release
// ============================================================================
module comma_window_detect
    import rx_align_pkg::*;
(
    input  logic [SYM_W-1:0] i_win,
    output logic             o_comma_hit
);

    // A window is a comma only when it matches one of the two K28.5 codes exactly.
    assign o_comma_hit = (i_win == K28_5_RDN) || (i_win == K28_5_RDP);

endmodule
`default_nettype wire

// File: rtl/rx_comma_aligner.sv
`default_nettype none
// ============================================================================
// Module      : rx_comma_aligner
// Description : Serial-to-symbol front end. Hunts for K28.5 at any bit
//               offset, locks the symbol phase after LOCK_CNT on-phase
//               commas, packs SYMS symbols per word with commas in lane 0,
//               and drops lock after UNLOCK_CNT off-phase commas.
// Revision    : 1.0  initial release
// ============================================================================
module rx_comma_aligner
    import rx_align_pkg::*;
#(
    parameter int SYMS       = 1,
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enb,
    input  logic                  serialIn,
    output logic [SYM_W*SYMS-1:0] dataOut,
    output logic [SYMS-1:0]       kMask,
    output logic                  dataValid,
    output logic                  locked,
    output logic                  realign
);

    localparam int c_ww   = SYM_W * SYMS;
    localparam int c_ln_w = (SYMS > 1) ? $clog2(SYMS) : 1;
    localparam int c_mw   = $clog2(LOCK_CNT + 1);
    localparam int c_uw   = $clog2(UNLOCK_CNT + 1);

    localparam logic [c_ln_w-1:0] c_last_ln  = c_ln_w'(SYMS - 1);
    localparam logic [c_mw-1:0]   c_lock_v   = c_mw'(LOCK_CNT);
    localparam logic [c_uw-1:0]   c_unlock_v = c_uw'(UNLOCK_CNT);

    align_state_e      state_q, state_d;
    logic [8:0]        sr_q, sr_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [c_ln_w-1:0] ln_q, ln_d;
    logic [c_mw-1:0]   match_q, match_d;
    logic [c_uw-1:0]   miss_q, miss_d;
    logic [c_ww-1:0]   word_q, word_d;
    logic [SYMS-1:0]   kbuf_q, kbuf_d;
    logic [c_ww-1:0]   data_out_q, data_out_d;
    logic [SYMS-1:0]   kmask_q, kmask_d;
    logic              valid_q, valid_d;
    logic              realign_q, realign_d;

    logic [SYM_W-1:0]  w_win;
    logic              w_comma_hit;
    logic              w_boundary;
    logic              w_wr_en;
    logic [c_ln_w-1:0] w_wr_ln;

    // Newest bit enters at the LSB so the oldest (bit a) lands at the MSB.
    assign w_win      = {sr_q, serialIn};
    assign w_boundary = (bit_cnt_q == 4'd9);

    comma_window_detect u_det (
        .i_win       (w_win),
        .o_comma_hit (w_comma_hit)
    );

    // Next-state, lane fill and output staging; everything holds when enb=0.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        ln_d       = ln_q;
        match_d    = match_q;
        miss_d     = miss_q;
        word_d     = word_q;
        kbuf_d     = kbuf_q;
        data_out_d = data_out_q;
        kmask_d    = kmask_q;
        valid_d    = 1'b0;
        realign_d  = 1'b0;
        w_wr_en    = 1'b0;
        w_wr_ln    = ln_q;

        if (enb) begin
            sr_d      = w_win[8:0];
            bit_cnt_d = w_boundary ? 4'd0 : bit_cnt_q + 4'd1;

            unique case (state_q)
                HUNT: begin
                    if (w_comma_hit) begin
                        // The comma's last bit becomes bit 9 of the symbol.
                        realign_d = 1'b1;
                        bit_cnt_d = 4'd0;
                        match_d   = c_mw'(1);
                        if (LOCK_CNT == 1) begin
                            state_d = LOCKED;
                            w_wr_en = 1'b1;
                            w_wr_ln = '0;
                            miss_d  = '0;
                        end else begin
                            state_d = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (w_comma_hit) begin
                        if (w_boundary) begin
                            match_d = match_q + 1'b1;
                            if (match_d == c_lock_v) begin
                                state_d = LOCKED;
                                w_wr_en = 1'b1;
                                w_wr_ln = '0;
                                miss_d  = '0;
                            end
                        end else begin
                            // Comma at a new phase: restart the count there.
                            realign_d = 1'b1;
                            bit_cnt_d = 4'd0;
                            match_d   = c_mw'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (w_boundary) begin
                        w_wr_en = 1'b1;
                        w_wr_ln = ln_q;
                        if (w_comma_hit) begin
                            miss_d = '0;
                            // Comma mid-word: abandon the partial word and restart at lane 0.
                            if (ln_q != '0) begin
                                w_wr_ln   = '0;
                                realign_d = 1'b1;
                            end
                        end
                    end else if (w_comma_hit) begin
                        miss_d = miss_q + 1'b1;
                        if (miss_d == c_unlock_v) begin
                            state_d   = HUNT;
                            ln_d      = '0;
                            match_d   = '0;
                            miss_d    = '0;
                            bit_cnt_d = 4'd0;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase

            if (w_wr_en) begin
                for (int i = 0; i < SYMS; i++) begin
                    if (w_wr_ln == c_ln_w'(i)) begin
                        word_d[(SYMS-1-i)*SYM_W +: SYM_W] = w_win;
                        kbuf_d[SYMS-1-i]                  = w_comma_hit;
                    end
                end
                if (w_wr_ln == c_last_ln) begin
                    data_out_d = word_d;
                    kmask_d    = kbuf_d;
                    valid_d    = 1'b1;
                    ln_d       = '0;
                end else begin
                    ln_d = w_wr_ln + 1'b1;
                end
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            ln_q       <= '0;
            match_q    <= '0;
            miss_q     <= '0;
            word_q     <= '0;
            kbuf_q     <= '0;
            data_out_q <= '0;
            kmask_q    <= '0;
            valid_q    <= 1'b0;
            realign_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            ln_q       <= ln_d;
            match_q    <= match_d;
            miss_q     <= miss_d;
            word_q     <= word_d;
            kbuf_q     <= kbuf_d;
            data_out_q <= data_out_d;
            kmask_q    <= kmask_d;
            valid_q    <= valid_d;
            realign_q  <= realign_d;
        end
    end

    assign dataOut   = data_out_q;
    assign kMask     = kmask_q;
    assign dataValid = valid_q;
    assign realign   = realign_q;
    assign locked    = (state_q == LOCKED);

endmodule
`default_nettype wire
